// File: rtl/counter123_rr_arbiter.sv
// counter123_rr_arbiter: round-robin arbiter time-sharing one (1,2,3) bit counter among NREQ requesters.
// Define COUNTER123_ARB_NOS1_EN to remove the operand register stage (latency 1 instead of 2).
module Counter_123 #(
    parameter OUTREG = "FALSE"
) (
    input  logic       clk,
    input  logic [2:0] c0,
    input  logic [1:0] c1,
    input  logic       c2,
    output logic [3:0] sum
);
    logic [3:0] s;

    assign s = {3'b0, c0[0]} + {3'b0, c0[1]} + {3'b0, c0[2]}
             + {2'b0, c1[0], 1'b0} + {2'b0, c1[1], 1'b0} + {1'b0, c2, 2'b0};

    generate
        if (OUTREG == "TRUE") begin : g_reg
            always_ff @(posedge clk) sum <= s;
        end else begin : g_comb
            logic unused_clk;
            assign unused_clk = clk;
            assign sum = s;
        end
    endgenerate
endmodule

module counter123_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [6*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [3:0]        rsp_sum,
    output logic [IDW-1:0]    rsp_id
);
    logic [IDW-1:0] last, cand, idx, cnt_id;
    logic [5:0]     gnt_data, cnt_data;
    logic [3:0]     cnt_sum;
    logic           found, hs, s1_free, s2_free, cnt_valid;
`ifndef COUNTER123_ARB_NOS1_EN
    logic           s1_valid;
    logic [5:0]     s1_data;
    logic [IDW-1:0] s1_id;
`endif

    // First valid requester after the last accepted one, wrapping modulo NREQ.
    always_comb begin
        cand = last;
        idx = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(last) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                cand = idx;
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NREQ; i++)
            gnt_data = (cand == IDW'(i)) ? req_data[6*i +: 6] : gnt_data;
    end

    assign s2_free = !rsp_valid | rsp_ready;
`ifdef COUNTER123_ARB_NOS1_EN
    assign s1_free   = s2_free;
    assign cnt_data  = gnt_data;
    assign cnt_id    = cand;
    assign cnt_valid = hs;
`else
    assign s1_free   = !s1_valid | s2_free;
    assign cnt_data  = s1_data;
    assign cnt_id    = s1_id;
    assign cnt_valid = s1_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else begin
            if (s1_free) s1_valid <= hs;
            if (hs) begin
                s1_data <= gnt_data;
                s1_id   <= cand;
            end
        end
    end
`endif

    assign hs        = found & s1_free & !rst;
    assign req_ready = hs ? NREQ'(1) << cand : '0;

    Counter_123 #(.OUTREG("FALSE")) u_cnt (
        .clk (clk),
        .c0  (cnt_data[2:0]),
        .c1  (cnt_data[4:3]),
        .c2  (cnt_data[5]),
        .sum (cnt_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_id    <= '0;
            last      <= IDW'(NREQ - 1);
        end else begin
            if (hs) last <= cand;
            if (s2_free) rsp_valid <= cnt_valid;
            if (cnt_valid & s2_free) begin
                rsp_sum <= cnt_sum;
                rsp_id  <= cnt_id;
            end
        end
    end
endmodule

// File: tb/tb_counter123_rr_arbiter.sv
// tb_counter123_rr_arbiter: scoreboard bench for the round-robin (1,2,3) counter arbiter.
module tb_counter123_rr_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [6*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [3:0]        rsp_sum;
    logic [IDW-1:0]    rsp_id;

    int n_chk = 0, n_pass = 0, n_acc = 0;
    int id_q[$], sum_q[$], acc_log[$];
    logic [NREQ-1:0] acc_mask = '0;
    int exp_ord[6] = '{0, 1, 2, 3, 0, 1};

    int m_last = NREQ - 1, m_cand;
    bit m_s1v = 0, m_s2v = 0, s1f, s2f, m_hs, post_rst = 0, hold_chk = 0;
    logic [3:0] held_sum;
    logic [IDW-1:0] held_id;
    logic [NREQ-1:0] exp_rdy;

    counter123_rr_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic int wsum(input logic [5:0] d);
        return int'(d[0]) + int'(d[1]) + int'(d[2]) + 2*int'(d[3]) + 2*int'(d[4]) + 4*int'(d[5]);
    endfunction

    // Reference model and scoreboard, sampled mid-cycle on the falling edge.
    initial forever begin
        @(negedge clk);
        s2f = !m_s2v || rsp_ready;
`ifdef COUNTER123_ARB_NOS1_EN
        s1f = s2f;
`else
        s1f = !m_s1v || s2f;
`endif
        m_cand = -1;
        for (int k = 1; k <= NREQ; k++)
            if (m_cand < 0 && req_valid[(m_last + k) % NREQ]) m_cand = (m_last + k) % NREQ;
        exp_rdy = (!rst && m_cand >= 0 && s1f) ? NREQ'(1) << m_cand : '0;
        m_hs = |(exp_rdy & req_valid);
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("rsp_valid", 32'(rsp_valid), 32'(m_s2v));
        if (post_rst) begin
            check("rst_sum", 32'(rsp_sum), 0);
            check("rst_id", 32'(rsp_id), 0);
        end
        if (hold_chk && rsp_valid) begin
            check("hold_sum", 32'(rsp_sum), 32'(held_sum));
            check("hold_id", 32'(rsp_id), 32'(held_id));
        end
        hold_chk = rsp_valid && !rsp_ready && !rst;
        held_sum = rsp_sum;
        held_id  = rsp_id;
        acc_mask = req_valid & req_ready;
        for (int i = 0; i < NREQ; i++)
            if (acc_mask[i]) begin
                acc_log.push_back(i);
                n_acc++;
            end
        if (rsp_valid && rsp_ready) begin
            if (id_q.size() == 0) check("sb_underflow", 32'(rsp_valid), 0);
            else begin
                check("rsp_id", 32'(rsp_id), id_q.pop_front());
                check("rsp_sum", 32'(rsp_sum), sum_q.pop_front());
            end
        end
        if (m_hs) begin
            id_q.push_back(m_cand);
            sum_q.push_back(wsum(req_data[6*m_cand +: 6]));
        end
        if (rst) begin
            id_q.delete();
            sum_q.delete();
            m_s1v = 0;
            m_s2v = 0;
            m_last = NREQ - 1;
            post_rst = 1;
        end else begin
            post_rst = 0;
            if (m_hs) m_last = m_cand;
`ifdef COUNTER123_ARB_NOS1_EN
            if (s2f) m_s2v = m_hs;
`else
            if (s2f) m_s2v = m_s1v;
            if (s1f) m_s1v = m_hs;
`endif
        end
    end

    // Advance one cycle; optionally give each just-accepted requester a fresh operand.
    task automatic step(input bit refresh);
        @(posedge clk);
        #1;
        if (refresh)
            for (int i = 0; i < NREQ; i++)
                if (acc_mask[i]) req_data[6*i +: 6] = 6'($urandom);
    endtask

    task automatic wait_acc(input int r);
        for (int c = 0; c < 20; c++) begin
            step(0);
            if (acc_mask[r]) break;
        end
        check("acc_seen", 32'(acc_mask[r]), 1);
    endtask

    initial begin
        int v, base;
        rst = 1'b1;
        req_valid = '1;
        req_data = 24'($urandom);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        acc_log.delete();
        repeat (6) step(1);
        check("rr_count", acc_log.size(), 6);
        for (int i = 0; i < 6; i++)
            check("rr_order", i < acc_log.size() ? acc_log[i] : -1, exp_ord[i]);
        req_valid = '0;
        repeat (4) step(0);

        req_valid = 4'b0100;
        req_data[17:12] = 6'b111111;
        wait_acc(2);
        req_data[17:12] = 6'b000000;
        wait_acc(2);
        req_valid = '0;
        repeat (4) step(0);

        rsp_ready = 1'b0;
        req_valid = 4'b1010;
        base = n_acc;
        repeat (5) step(1);
        check("bp_accepts", n_acc - base, 2);
        check("bp_ready_zero", 32'(req_ready), 0);
        rsp_ready = 1'b1;
        repeat (6) step(1);
        req_valid = '0;
        repeat (4) step(0);

        req_valid = 4'b0001;
        req_data[5:0] = 6'd0;
        v = 0;
        for (int c = 0; c < 400 && v < 64; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            step(0);
            if (acc_mask[0]) begin
                v++;
                req_data[5:0] = 6'(v);
            end
        end
        check("sweep_done", v, 64);
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) step(0);

        req_valid = '1;
        rsp_ready = 1'b0;
        repeat (3) step(1);
        acc_log.delete();
        rst = 1'b1;
        step(0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) step(1);
        check("rst_first_grant", acc_log.size() > 0 ? acc_log[0] : -1, 0);
        req_valid = '0;
        repeat (5) step(0);
        check("sb_drained", id_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/counter123_rr_arbiter.md
# counter123_rr_arbiter

Round-robin arbiter and pipeline sequencer that time-shares one `Counter_123` (1,2,3)-weighted bit counter among `NREQ` requesters. Each requester presents six weighted input bits under a valid/ready handshake. The block grants one requester per cycle, drives the shared counter from a registered operand stage, and returns the 4-bit result tagged with the requester index. It sits between compression-tree control logic and the shared LUT-pair counter primitive, so several low-rate columns can reuse one counter.

## Interface
- `NREQ`, 4: number of requesters, 2..16.
- `IDW`, `$clog2(NREQ)`: width of the response tag.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input NREQ: requester i presents an operand.
- `req_data` input 6*NREQ: for requester i, `req_data[6i +: 6]` = {C2, C1[1:0], C0[2:0]}, with bit 6i being C0[0].
- `req_ready` output NREQ: one-hot or zero; an operand is accepted when `req_valid[i] & req_ready[i]`.
- `rsp_valid` output 1: a result is held.
- `rsp_ready` input 1: downstream accepts the result.
- `rsp_sum` output 4: sum = C0[0]+C0[1]+C0[2] + 2*(C1[0]+C1[1]) + 4*C2. Range 0..11.
- `rsp_id` output IDW: index of the requester that supplied the operand.

## Operation
- Datapath: one `Counter_123` instance with `OUTREG="FALSE"`. It is driven from stage-1 registers `s1_data[5:0]` and `s1_id`; it is never driven directly from `req_data`.
- Pipeline: stage 1 (operand and id plus `s1_valid`), then the counter (combinational), then stage 2 (`rsp_sum`, `rsp_id`, `rsp_valid`).
- Stall rules:
  - `s2_free = !rsp_valid | rsp_ready`.
  - `s1_free = !s1_valid | s2_free`.
  - Stage 2 loads from stage 1 when `s1_valid & s2_free`.
- Arbitration: the round-robin pointer `last[IDW-1:0]` holds the index of the last accepted requester.
  - The search order is last+1, last+2, … modulo NREQ, wrapping from NREQ-1 to 0.
  - The first valid requester in that order is the candidate.
- `req_ready[cand]` = `s1_free`. All other `req_ready` bits are 0.
- `req_ready` depends combinationally on `req_valid`, `s1_valid`, `rsp_valid` and `rsp_ready`. It never depends on `req_data`.
- On handshake: stage 1 loads the operand and `cand`, and `last <= cand`. With no handshake, `last` holds.
- Requesters must hold `req_valid` and `req_data` until accepted. A requester that drops `req_valid` before acceptance simply loses its turn, and no state is corrupted.
- Starvation bound: a continuously valid requester is accepted within NREQ handshakes.
- Arithmetic: the result is exactly the weighted sum above, with no overflow. The maximum is 3+4+4 = 11 = 4'hB.
- Reset values: `s1_valid=0`, `rsp_valid=0`, `rsp_sum=0`, `rsp_id=0`, `last=NREQ-1` (so requester 0 is favoured first). `req_ready` is all 0 during the reset cycle.

## Timing
- Latency: handshake in cycle t gives `rsp_valid=1` with the result in cycle t+2, provided `rsp_ready` was high or stage 2 was empty.
- Throughput: one result per cycle with `rsp_ready` held high and at least one requester valid.
- Backpressure: while `rsp_valid & !rsp_ready`, `rsp_sum` and `rsp_id` are stable. At most one further operand is accepted, filling stage 1, and then all `req_ready` bits are 0.
- Simultaneous drain and load: when `rsp_ready=1` and `s1_valid=1`, stage 2 reloads in the same edge. In that same edge stage 1 may accept a new operand, so there is no bubble.
- Reset mid-operation: asserting `rst` on any edge discards stage 1 and stage 2 contents. In-flight operands are lost and no response is produced. Arbitration restarts from requester 0.

## Configuration
- `COUNTER123_ARB_NOS1_EN`: when defined, the stage-1 register is removed.
  - The counter is fed from the granted `req_data` through a NREQ:1 mux.
  - Latency becomes 1 (handshake in t, response in t+1).
  - `s1_free` is replaced by `s2_free`.
- When `COUNTER123_ARB_NOS1_EN` is undefined (the default), the two-stage behaviour above applies.
- Arbitration order, reset values and result arithmetic are identical in both builds.

## Test plan
- Reset: hold `rst` for 3 cycles with all `req_valid=1`. Required: `req_ready=0`, `rsp_valid=0`, `rsp_sum=0`. After release, the first grant goes to requester 0.
- Single requester: requester 2 sends `req_data=6'b111111` with `rsp_ready=1`. Required: `rsp_sum=4'd11`, `rsp_id=2`, 2 cycles after the handshake. Then send `6'b000000` and require `rsp_sum=0`.
- Round-robin wrap: with NREQ=4, all requesters valid continuously and `rsp_ready=1`. Required: acceptance order 0,1,2,3,0,1 and one response per cycle.
- Backpressure: `rsp_ready=0` for 5 cycles with requesters 1 and 3 valid. Required: exactly one further acceptance, then `req_ready=0`, and `rsp_sum`/`rsp_id` stable. Release `rsp_ready` and require in-order responses with no loss or duplication.
- Exhaustive arithmetic: sweep all 64 `req_data` values through requester 0. Required: every `rsp_sum` equals the weighted-sum model.
- Mid-flight reset: assert `rst` for 1 cycle while both stages are full. Required: `rsp_valid=0` the next cycle, no stale result emitted, and the next grant goes to requester 0.
